// File: rtl/regfile_wr_arbiter_if.sv
// Signal bundle between the writeback sources, the write-port arbiter and the register file.
// The arbiter takes the slave side; the requesters and register file take the master side.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rd_addr1;
  logic [ADDR_W-1:0]         rd_addr2;
  logic                      rd_hazard1;
  logic                      rd_hazard2;
  logic                      rf_wr_en;
  logic [ADDR_W-1:0]         rf_wr_addr;
  logic [DATA_W-1:0]         rf_wr_data;
  logic                      init_done;

  modport master (
    output req_valid, req_addr, req_data, rd_addr1, rd_addr2,
    input  req_ready, rd_hazard1, rd_hazard2, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data, rd_addr1, rd_addr2,
    output req_ready, rd_hazard1, rd_hazard2, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register file write port; zero-fills the file after reset
// and flags reads that hit a write still registered on the port.
//
// state  | meaning
// S_INIT | writing zero to address init_cnt each cycle, requesters held off
// S_RUN  | round-robin arbitration of writeback requesters, one write per cycle
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wr_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                init_done_q, init_done_d;

  logic [NUM_REQ-1:0]  grant;
  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W:0]      scan;
  logic [PTR_W:0]      ptr_nxt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Scan from rr_ptr with an explicit wrap so non-power-of-two NUM_REQ never
  // lands on an unused index.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
        if (scan >= (PTR_W+1)'(NUM_REQ))
          scan = scan - (PTR_W+1)'(NUM_REQ);
        if (!grant_any && bus.req_valid[scan[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan[PTR_W-1:0];
        end
      end
    end
    if (grant_any)
      grant[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_nxt = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (ptr_nxt == (PTR_W+1)'(NUM_REQ))
      ptr_nxt = '0;
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;
    case (state_q)
      S_INIT: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = init_cnt_q;
        wr_data_d  = '0;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_RUN: begin
        if (grant_any) begin
          wr_en_d   = 1'b1;
          wr_addr_d = sel_addr;
          wr_data_d = sel_data;
          rr_ptr_d  = ptr_nxt[PTR_W-1:0];
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_addr_q;
  assign bus.rf_wr_data = wr_data_q;
  assign bus.init_done  = init_done_q;

  // Until the zero-fill finishes every read is treated as hitting an unwritten entry.
  assign bus.rd_hazard1 = ~init_done_q | (wr_en_q & (wr_addr_q == bus.rd_addr1));
  assign bus.rd_hazard2 = ~init_done_q | (wr_en_q & (wr_addr_q == bus.rd_addr2));
endmodule
